// File: rtl/dynode_pkg.sv
// Shared widths and event-word layout for the dynode event path.
// The event word is packed MSB first as {pulookup, dyn_enecor, dyn_evntim}.
package dynode_pkg;

  localparam int DYN_ENE_W  = 12;
  localparam int DYN_TIM_W  = 24;
  localparam int DYN_PUL_W  = 8;
  localparam int DYN_EVW    = DYN_PUL_W + DYN_ENE_W + DYN_TIM_W;

  localparam int DYN_TIM_LSB = 0;
  localparam int DYN_ENE_LSB = DYN_TIM_LSB + DYN_TIM_W;
  localparam int DYN_PUL_LSB = DYN_ENE_LSB + DYN_ENE_W;

  localparam int DYN_CNT_W  = 7;
  localparam int DYN_DROP_W = 16;

  function automatic logic [DYN_EVW-1:0] dyn_pack_event(
    input logic [DYN_PUL_W-1:0] pul,
    input logic [DYN_ENE_W-1:0] ene,
    input logic [DYN_TIM_W-1:0] tim
  );
    logic [DYN_EVW-1:0] word;
    word = '0;
    word[DYN_PUL_LSB +: DYN_PUL_W] = pul;
    word[DYN_ENE_LSB +: DYN_ENE_W] = ene;
    word[DYN_TIM_LSB +: DYN_TIM_W] = tim;
    return word;
  endfunction

endpackage

// File: rtl/dynode_evbuf_ram.sv
// Simple dual-port event buffer with one write port and a registered read port.
// The read register is cleared by reset so the FIFO output starts at zero.
module dynode_evbuf_ram
  import dynode_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DYN_EVW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output holds its last value until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dynode_event_fifo.sv
// Event FIFO between the pileup-correction stage and readout, with drop counting.
// Define DYN_ENEWIN_EN to compile in the inclusive energy-window filter.
module dynode_event_fifo
  import dynode_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DYN_ENE_W-1:0]  dyn_enecor,
  input  logic [DYN_TIM_W-1:0]  dyn_evntim,
  input  logic [DYN_PUL_W-1:0]  pulookup,
  input  logic                  enecor_load,
  input  logic [DYN_ENE_W-1:0]  enewin_lo,
  input  logic [DYN_ENE_W-1:0]  enewin_hi,
  input  logic                  fifo_clr,
  input  logic                  rd_en,
  output logic [DYN_EVW-1:0]    ev_dout,
  output logic                  ev_valid,
  output logic                  ev_empty,
  output logic                  ev_full,
  output logic [DYN_CNT_W-1:0]  ev_count,
  output logic [DYN_DROP_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DYN_CNT_W-1:0] FULL_CNT = DYN_CNT_W'(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DYN_CNT_W-1:0]  count_q;
  logic [DYN_DROP_W-1:0] drop_q;
  logic                  valid_q;
  logic                  accept;
  logic                  wr_do;
  logic                  rd_do;
  logic                  drop_do;
  logic [DYN_EVW-1:0]    wr_word;

`ifdef DYN_ENEWIN_EN
  // An inverted window (lo > hi) rejects everything.
  assign accept = (enewin_lo <= enewin_hi) &&
                  (dyn_enecor >= enewin_lo) &&
                  (dyn_enecor <= enewin_hi);
`else
  logic unused_win;
  assign unused_win = ^{enewin_lo, enewin_hi};
  assign accept     = 1'b1;
`endif

  assign ev_empty = (count_q == '0);
  assign ev_full  = (count_q == FULL_CNT);
  assign ev_count = count_q;
  assign drop_cnt = drop_q;
  assign ev_valid = valid_q;
  assign wr_word  = dyn_pack_event(pulookup, dyn_enecor, dyn_evntim);

  // A full FIFO drops the event even if a read frees a slot on the same edge.
  always_comb begin
    wr_do   = 1'b0;
    rd_do   = 1'b0;
    drop_do = 1'b0;
    if (!reset && !fifo_clr) begin
      wr_do   = enecor_load && accept && !ev_full;
      drop_do = enecor_load && accept && ev_full;
      rd_do   = rd_en && !ev_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fifo_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_do;
      if (wr_do) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_do) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_do, rd_do})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop_do && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  dynode_evbuf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DYN_EVW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_do),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_do),
    .rd_addr (rd_ptr),
    .rd_data (ev_dout)
  );

endmodule

// File: tb/tb_dynode_event_fifo.sv
// Directed self-checking bench for dynode_event_fifo (DEPTH=16).
// Covers both builds; window-specific steps depend on DYN_ENEWIN_EN.
module tb_dynode_event_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] dyn_enecor;
  logic [23:0] dyn_evntim;
  logic [7:0]  pulookup;
  logic        enecor_load;
  logic [11:0] enewin_lo;
  logic [11:0] enewin_hi;
  logic        fifo_clr;
  logic        rd_en;
  logic [43:0] ev_dout;
  logic        ev_valid;
  logic        ev_empty;
  logic        ev_full;
  logic [6:0]  ev_count;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dynode_event_fifo #(.DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dyn_enecor  (dyn_enecor),
    .dyn_evntim  (dyn_evntim),
    .pulookup    (pulookup),
    .enecor_load (enecor_load),
    .enewin_lo   (enewin_lo),
    .enewin_hi   (enewin_hi),
    .fifo_clr    (fifo_clr),
    .rd_en       (rd_en),
    .ev_dout     (ev_dout),
    .ev_valid    (ev_valid),
    .ev_empty    (ev_empty),
    .ev_full     (ev_full),
    .ev_count    (ev_count),
    .drop_cnt    (drop_cnt)
  );

  function automatic logic [11:0] evE(input int i);
    return 12'h010 + 12'(i);
  endfunction

  function automatic logic [23:0] evT(input int i);
    return 24'h0A0000 | 24'(i);
  endfunction

  function automatic logic [7:0] evP(input int i);
    return 8'h80 ^ 8'(i);
  endfunction

  function automatic logic [63:0] word(input int i);
    return {20'h0, evP(i), evE(i), evT(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic rd, input logic clr,
                               input logic [11:0] ene, input logic [23:0] tim,
                               input logic [7:0] pul);
    enecor_load = load;
    rd_en       = rd;
    fifo_clr    = clr;
    dyn_enecor  = ene;
    dyn_evntim  = tim;
    pulookup    = pul;
    tick();
    enecor_load = 1'b0;
    rd_en       = 1'b0;
    fifo_clr    = 1'b0;
  endtask

  task automatic writeEv(input int i);
    applyStimulus(1'b1, 1'b0, 1'b0, evE(i), evT(i), evP(i));
  endtask

  task automatic readEv();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h0, 24'h0, 8'h0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dout"},  64'(ev_dout),  64'h0);
    checkOutput({tag, "_valid"}, 64'(ev_valid), 64'h0);
    checkOutput({tag, "_empty"}, 64'(ev_empty), 64'h1);
    checkOutput({tag, "_full"},  64'(ev_full),  64'h0);
    checkOutput({tag, "_count"}, 64'(ev_count), 64'h0);
    checkOutput({tag, "_drop"},  64'(drop_cnt), 64'h0);
  endtask

  initial begin
    reset       = 1'b1;
    dyn_enecor  = '0;
    dyn_evntim  = '0;
    pulookup    = '0;
    enecor_load = 1'b0;
    enewin_lo   = 12'h000;
    enewin_hi   = 12'hFFF;
    fifo_clr    = 1'b0;
    rd_en       = 1'b0;

    // Reset values
    tick();
    tick();
    checkResetState("rst");
    reset = 1'b0;
    tick();

    // Basic write / read of three events
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h100, 24'h001100, 8'h41);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h200, 24'h002200, 8'h52);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h300, 24'h003300, 8'h63);
    checkOutput("basic_count3", 64'(ev_count), 64'd3);
    readEv();
    checkOutput("basic_v0", 64'(ev_valid), 64'h1);
    checkOutput("basic_d0", 64'(ev_dout), 64'h41_100_001100);
    readEv();
    checkOutput("basic_v1", 64'(ev_valid), 64'h1);
    checkOutput("basic_d1", 64'(ev_dout), 64'h52_200_002200);
    readEv();
    checkOutput("basic_v2", 64'(ev_valid), 64'h1);
    checkOutput("basic_d2", 64'(ev_dout), 64'h63_300_003300);
    tick();
    checkOutput("basic_vidle", 64'(ev_valid), 64'h0);
    checkOutput("basic_hold", 64'(ev_dout), 64'h63_300_003300);
    checkOutput("basic_count0", 64'(ev_count), 64'd0);
    checkOutput("basic_empty", 64'(ev_empty), 64'h1);

    // Fill past full: 18 writes, 2 dropped
    for (int i = 0; i < 18; i++) writeEv(i);
    checkOutput("full_flag", 64'(ev_full), 64'h1);
    checkOutput("full_count", 64'(ev_count), 64'd16);
    checkOutput("full_drop", 64'(drop_cnt), 64'd2);
    // Write while full plus read: write still dropped
    applyStimulus(1'b1, 1'b1, 1'b0, evE(99), evT(99), evP(99));
    checkOutput("fullrw_valid", 64'(ev_valid), 64'h1);
    checkOutput("fullrw_dout", 64'(ev_dout), word(0));
    checkOutput("fullrw_count", 64'(ev_count), 64'd15);
    checkOutput("fullrw_drop", 64'(drop_cnt), 64'd3);
    for (int i = 1; i < 16; i++) begin
      readEv();
      checkOutput("full_rd_valid", 64'(ev_valid), 64'h1);
      checkOutput("full_rd_dout", 64'(ev_dout), word(i));
    end
    checkOutput("full_drained", 64'(ev_empty), 64'h1);

    // Simultaneous read/write on empty: write only
    applyStimulus(1'b1, 1'b1, 1'b0, evE(20), evT(20), evP(20));
    checkOutput("simE_count", 64'(ev_count), 64'd1);
    checkOutput("simE_valid", 64'(ev_valid), 64'h0);
    for (int i = 21; i < 25; i++) writeEv(i);
    checkOutput("sim5_pre", 64'(ev_count), 64'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, evE(25), evT(25), evP(25));
    checkOutput("sim5_count", 64'(ev_count), 64'd5);
    checkOutput("sim5_valid", 64'(ev_valid), 64'h1);
    checkOutput("sim5_dout", 64'(ev_dout), word(20));
    checkOutput("sim5_drop", 64'(drop_cnt), 64'd3);

    // Flush with a concurrent read
    for (int i = 26; i < 31; i++) writeEv(i);
    checkOutput("flush_pre", 64'(ev_count), 64'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h0, 24'h0, 8'h0);
    checkOutput("flush_count", 64'(ev_count), 64'd0);
    checkOutput("flush_empty", 64'(ev_empty), 64'h1);
    checkOutput("flush_drop", 64'(drop_cnt), 64'd0);
    checkOutput("flush_valid", 64'(ev_valid), 64'h0);
    writeEv(31);
    readEv();
    checkOutput("flush_after", 64'(ev_dout), word(31));

    // Mid-operation reset with a read in flight
    for (int i = 0; i < 18; i++) writeEv(i);
    readEv();
    checkOutput("mrst_pre", 64'(ev_dout), word(0));
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h0, 24'h0, 8'h0);
    reset = 1'b0;
    checkResetState("mrst");
    tick();
    checkOutput("mrst_idle_valid", 64'(ev_valid), 64'h0);

`ifdef DYN_ENEWIN_EN
    // Window boundaries: only 080 and 3FF are inside
    enewin_lo = 12'h080;
    enewin_hi = 12'h3FF;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h07F, evT(40), evP(40));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h080, evT(41), evP(41));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h3FF, evT(42), evP(42));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h400, evT(43), evP(43));
    checkOutput("win_count", 64'(ev_count), 64'd2);
    checkOutput("win_drop", 64'(drop_cnt), 64'd0);
    readEv();
    checkOutput("win_d0", 64'(ev_dout), {20'h0, evP(41), 12'h080, evT(41)});
    readEv();
    checkOutput("win_d1", 64'(ev_dout), {20'h0, evP(42), 12'h3FF, evT(42)});
    enewin_lo = 12'h200;
    enewin_hi = 12'h100;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h180, evT(44), evP(44));
    checkOutput("winbad_count", 64'(ev_count), 64'd0);
    checkOutput("winbad_drop", 64'(drop_cnt), 64'd0);
`else
    // Window inputs are ignored in this build, even when inverted
    enewin_lo = 12'h200;
    enewin_hi = 12'h100;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h07F, evT(40), evP(40));
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h400, evT(43), evP(43));
    checkOutput("nowin_count", 64'(ev_count), 64'd2);
    readEv();
    checkOutput("nowin_d0", 64'(ev_dout), {20'h0, evP(40), 12'h07F, evT(40)});
    readEv();
    checkOutput("nowin_d1", 64'(ev_dout), {20'h0, evP(43), 12'h400, evT(43)});
`endif
    enewin_lo = 12'h000;
    enewin_hi = 12'hFFF;

    // Interleaved write/read pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      writeEv(50 + i);
      readEv();
      checkOutput("wrap_valid", 64'(ev_valid), 64'h1);
      checkOutput("wrap_dout", 64'(ev_dout), word(50 + i));
    end
    checkOutput("wrap_drop", 64'(drop_cnt), 64'd0);
    checkOutput("wrap_empty", 64'(ev_empty), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
